// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and limits for the CPU/DMA external memory port arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } arb_owner_t;

  localparam int unsigned WAIT_CYCLES_MAX = 15;
  localparam int unsigned WAIT_CNT_W      = 4;

endpackage

// File: rtl/mem_bus_arbiter_wait_counter.sv
// Loadable 4-bit down-counter that times the memory wait states of one transfer.
module arb_wait_counter
  import mem_bus_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] loadVal,
  input  logic                  en,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count;

  // Saturates at zero so a stray enable can never wrap into a long wait.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the external SRAM port between the CPU and a DMA/loader.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rnw,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_rnw,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbgState
);

  // Handshake: each requester holds req high as a level until its one-cycle
  // completion strobe; inputs are sampled only on the IDLE->ACCESS edge, and
  // a transfer always runs to its strobe even if req drops meanwhile.

  localparam logic [WAIT_CNT_W-1:0] LOAD_VAL = WAIT_CNT_W'(WAIT_CYCLES - 1);

  arb_state_t  state;
  arb_owner_t  owner;
  arb_owner_t  lastGrant;
  arb_owner_t  grantOwner;
  logic        anyReq;
  logic        grantDma;
  logic        cntLoad;
  logic        cntEn;
  logic        cntZero;

  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic              latRnw;
  logic              memWeQ;
  logic              memOeQ;
  logic              cpuReadyQ;
  logic              dmaDoneQ;
  logic [DATA_W-1:0] cpuRdataQ;
  logic [DATA_W-1:0] dmaRdataQ;

  // DMA wins when it is alone, or on a tie when the CPU had the previous grant.
  assign anyReq     = cpu_req | dma_req;
  assign grantDma   = dma_req & (~cpu_req | (lastGrant == OWNER_CPU));
  assign grantOwner = grantDma ? OWNER_DMA : OWNER_CPU;

  assign cntLoad = (state == IDLE) && anyReq;
  assign cntEn   = (state == ACCESS);

  arb_wait_counter u_wait_counter (
    .clk     (clk),
    .nrst    (nrst),
    .load    (cntLoad),
    .loadVal (LOAD_VAL),
    .en      (cntEn),
    .zero    (cntZero)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      owner     <= OWNER_CPU;
      lastGrant <= OWNER_DMA;
      latAddr   <= '0;
      latWdata  <= '0;
      latRnw    <= 1'b0;
      memWeQ    <= 1'b0;
      memOeQ    <= 1'b0;
      cpuReadyQ <= 1'b0;
      dmaDoneQ  <= 1'b0;
      cpuRdataQ <= '0;
      dmaRdataQ <= '0;
    end else begin
      cpuReadyQ <= 1'b0;
      dmaDoneQ  <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner     <= grantOwner;
            lastGrant <= grantOwner;
            if (grantDma) begin
              latAddr  <= dma_addr;
              latWdata <= dma_wdata;
              latRnw   <= dma_rnw;
              memOeQ   <= dma_rnw;
              memWeQ   <= ~dma_rnw;
            end else begin
              latAddr  <= cpu_addr;
              latWdata <= cpu_wdata;
              latRnw   <= cpu_rnw;
              memOeQ   <= cpu_rnw;
              memWeQ   <= ~cpu_rnw;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cntZero) begin
            memOeQ <= 1'b0;
            memWeQ <= 1'b0;
            if (owner == OWNER_CPU) begin
              cpuReadyQ <= 1'b1;
              if (latRnw) cpuRdataQ <= mem_rdata;
            end else begin
              dmaDoneQ <= 1'b1;
              if (latRnw) dmaRdataQ <= mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = latAddr;
  assign mem_wdata = latWdata;
  assign mem_we    = memWeQ;
  assign mem_oe    = memOeQ;
  assign cpu_ready = cpuReadyQ;
  assign dma_done  = dmaDoneQ;
  assign cpu_rdata = cpuRdataQ;
  assign dma_rdata = dmaRdataQ;
  assign busy      = (state != IDLE);
  assign dbgState  = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with WAIT_CYCLES=2 and hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cpu_req, cpu_rnw, dma_req, dma_rnw;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
  logic        cpu_ready, dma_done, mem_we, mem_oe, busy;
  logic [1:0]  dbgState;

  int nChecks = 0;
  int nPass   = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WAIT_CYCLES(2), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw), .dma_wdata(dma_wdata),
    .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata), .busy(busy), .dbgState(dbgState)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else nPass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lastStrobe;
    int cyc;
    nrst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 16'hFFFC; cpu_rnw = 1'b1; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_addr = 16'h0000; dma_rnw = 1'b1; dma_wdata = 8'h00;
    mem_rdata = 8'h34;

    // Reset with a pending CPU request
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_oe", mem_oe, 0);
    check("rst_we", mem_we, 0);
    check("rst_ready", cpu_ready, 0);
    check("rst_done", dma_done, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_crdata", cpu_rdata, 0);
    check("rst_drdata", dma_rdata, 0);

    // CPU read at FFFC; cycle 0 is this IDLE cycle
    nrst = 1'b1;
    tick();
    check("rd_c1_state", dbgState, 1);
    check("rd_c1_oe", mem_oe, 1);
    check("rd_c1_we", mem_we, 0);
    check("rd_c1_addr", mem_addr, 16'hFFFC);
    check("rd_c1_ready", cpu_ready, 0);
    tick();
    check("rd_c2_oe", mem_oe, 1);
    check("rd_c2_addr", mem_addr, 16'hFFFC);
    check("rd_c2_ready", cpu_ready, 0);
    tick();
    cpu_req = 1'b0;
    check("rd_c3_ready", cpu_ready, 1);
    check("rd_c3_rdata", cpu_rdata, 8'h34);
    check("rd_c3_oe", mem_oe, 0);
    check("rd_c3_busy", busy, 1);
    check("rd_c3_dmadone", dma_done, 0);
    tick();
    check("rd_c4_busy", busy, 0);
    check("rd_c4_ready", cpu_ready, 0);

    // DMA write: rdata registers must not move
    dma_req = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'hA5; dma_rnw = 1'b0;
    mem_rdata = 8'hEE;
    tick();
    check("wr_c1_we", mem_we, 1);
    check("wr_c1_oe", mem_oe, 0);
    check("wr_c1_wdata", mem_wdata, 8'hA5);
    check("wr_c1_addr", mem_addr, 16'h0200);
    tick();
    check("wr_c2_we", mem_we, 1);
    check("wr_c2_done", dma_done, 0);
    tick();
    dma_req = 1'b0;
    check("wr_c3_done", dma_done, 1);
    check("wr_c3_ready", cpu_ready, 0);
    check("wr_c3_we", mem_we, 0);
    check("wr_c3_drdata", dma_rdata, 8'h00);
    check("wr_c3_crdata", cpu_rdata, 8'h34);
    tick();
    check("wr_c4_done", dma_done, 0);
    check("wr_c4_busy", busy, 0);

    // Contention: CPU writes, DMA reads; last grant was DMA so CPU goes first
    cpu_req = 1'b1; cpu_addr = 16'h1000; cpu_rnw = 1'b0; cpu_wdata = 8'h11;
    dma_req = 1'b1; dma_addr = 16'h2000; dma_rnw = 1'b1;
    mem_rdata = 8'h5A;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    lastStrobe = 0;
    for (cyc = 1; cyc <= 15; cyc++) begin
      tick();
      if (cpu_ready || dma_done) begin
        if (exp_q.size() == 0) begin
          check("cont_extra_strobe", {dma_done, cpu_ready}, 2'b00);
        end else begin
          check("cont_owner", {dma_done, cpu_ready}, exp_q.pop_front());
          check("cont_spacing", cyc - lastStrobe, (lastStrobe == 0) ? 3 : 4);
        end
        lastStrobe = cyc;
      end
      if (cyc == 15) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
    check("cont_all_strobes", exp_q.size(), 0);
    tick();
    check("cont_idle_busy", busy, 0);
    check("cont_drdata", dma_rdata, 8'h5A);
    check("cont_crdata", cpu_rdata, 8'h34);

    // Withdrawal in the first ACCESS cycle
    cpu_req = 1'b1; cpu_addr = 16'h0040; cpu_rnw = 1'b1;
    mem_rdata = 8'hC3;
    tick();
    cpu_req = 1'b0;
    check("wd_c1_busy", busy, 1);
    tick();
    check("wd_c2_oe", mem_oe, 1);
    tick();
    check("wd_c3_ready", cpu_ready, 1);
    check("wd_c3_rdata", cpu_rdata, 8'hC3);
    tick();
    check("wd_c4_busy", busy, 0);
    check("wd_c4_ready", cpu_ready, 0);
    tick();
    check("wd_c5_busy", busy, 0);

    // Reset pulsed during ACCESS aborts the transfer
    cpu_req = 1'b1; cpu_addr = 16'h0080; cpu_rnw = 1'b1;
    mem_rdata = 8'h99;
    tick();
    check("ab_c1_busy", busy, 1);
    cpu_req = 1'b0;
    #2 nrst = 1'b0;
    #1;
    check("ab_state", dbgState, 0);
    check("ab_busy", busy, 0);
    check("ab_oe", mem_oe, 0);
    check("ab_crdata", cpu_rdata, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_no_ready", cpu_ready, 0);
    end
    nrst = 1'b1;

    // Tie right after reset goes to the CPU
    cpu_req = 1'b1; cpu_addr = 16'h0080; cpu_rnw = 1'b1;
    dma_req = 1'b1; dma_addr = 16'h0300; dma_rnw = 1'b0;
    tick();
    cpu_req = 1'b0;
    dma_req = 1'b0;
    check("tie_oe", mem_oe, 1);
    check("tie_we", mem_we, 0);
    check("tie_addr", mem_addr, 16'h0080);
    tick();
    tick();
    check("tie_ready", cpu_ready, 1);
    check("tie_dmadone", dma_done, 0);
    check("tie_rdata", cpu_rdata, 8'h99);
    tick();
    check("tie_idle", busy, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory port between the CPU core and a secondary DMA/loader requester. It serialises accesses, inserts a fixed number of memory wait states, and returns a one-cycle completion strobe to the winning requester. The CPU side of this strobe drives the core's `ready` input. The block sits between the CPU top level and the external SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: memory access cycles per transfer, legal range 1–15.
- `ADDR_W`, default 16: address width (AddressBusHigh concatenated with AddressBusLow).
- `DATA_W`, default 8: data width.

Ports:
- `clk`, input, 1: system clock. One clock domain only.
- `nrst`, input, 1: asynchronous active-low reset.
- `cpu_req`, input, 1: CPU access request. Level; held until `cpu_ready`.
- `cpu_addr`, input, ADDR_W: CPU address.
- `cpu_rnw`, input, 1: 1 = read, 0 = write.
- `cpu_wdata`, input, DATA_W: CPU write data.
- `cpu_ready`, output, 1: one-cycle completion strobe for a CPU access.
- `cpu_rdata`, output, DATA_W: CPU read data. Held until the next CPU read completes.
- `dma_req`, input, 1: DMA request. Same rules as `cpu_req`.
- `dma_addr`, input, ADDR_W: DMA address.
- `dma_rnw`, input, 1: DMA read/write.
- `dma_wdata`, input, DATA_W: DMA write data.
- `dma_done`, output, 1: one-cycle completion strobe for a DMA access.
- `dma_rdata`, output, DATA_W: DMA read data. Held until the next DMA read completes.
- `mem_addr`, output, ADDR_W: memory address.
- `mem_wdata`, output, DATA_W: memory write data.
- `mem_we`, output, 1: memory write enable.
- `mem_oe`, output, 1: memory output enable.
- `mem_rdata`, input, DATA_W: memory read data.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: grant one requester, latch its addr/rnw/wdata into registers, load the wait counter with WAIT_CYCLES−1, go to ACCESS.
- **ACCESS**
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - `mem_oe` = latched rnw; `mem_we` = ~latched rnw.
  - Counter decrements each cycle. When the counter reads 0:
    - read: capture `mem_rdata` into the owner's rdata register;
    - go to DONE.
- **DONE**
  - `mem_we` = `mem_oe` = 0; `mem_addr` holds.
  - The owner's strobe (`cpu_ready` or `dma_done`) is high for exactly this cycle.
  - Next state is always IDLE.
- **Arbitration**
  - Only one requester active: that requester wins.
  - Both active: the requester that did not win the last grant wins (round-robin). `last_grant` updates on each IDLE→ACCESS transition.
- Requester inputs are sampled only at the IDLE→ACCESS transition. Changes during ACCESS or DONE are ignored.
- A request withdrawn mid-transfer still completes and still strobes.
- A requester that keeps its req high through DONE is treated as a new request in the following IDLE cycle.
- Read data registers are updated only on reads by their own owner. Writes leave both rdata registers unchanged.

## Timing
- Reset (asynchronous):
  - state = IDLE, counter = 0, `last_grant` = DMA, so the CPU wins the first tie.
  - All latched registers and both rdata registers = 0.
  - `cpu_ready`, `dma_done`, `mem_we`, `mem_oe`, `busy` = 0; `mem_addr` = 0; `mem_wdata` = 0.
- Reset asserted mid-transfer aborts it immediately: no strobe, no rdata update.
- Request high in cycle 0 (state IDLE):
  - ACCESS in cycles 1..WAIT_CYCLES;
  - DONE in cycle WAIT_CYCLES+1;
  - earliest next grant at the IDLE cycle WAIT_CYCLES+2.
- Per-transfer throughput: WAIT_CYCLES+2 cycles.
- `mem_rdata` is sampled at the clock edge that ends the last ACCESS cycle. Read data is visible on `*_rdata` in DONE.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- `mem_bus_arbiter_pkg` holds:
  - `arb_state_t` enum (IDLE, ACCESS, DONE);
  - `arb_owner_t` enum (OWNER_CPU, OWNER_DMA);
  - the legal WAIT_CYCLES bound constant.
- One sub-module, `arb_wait_counter`: a 4-bit loadable down-counter.
  - Inputs: load, load value, enable.
  - Output: zero flag.
  - Asynchronous reset on `nrst`.
- The FSM, arbitration and output registers live in the top module.

## Test plan
- **Reset values:** `nrst` low with `cpu_req`=1 → all outputs 0, `busy`=0; first grant after release goes to the CPU.
- **CPU read, WAIT_CYCLES=2:** `cpu_addr`=16'hFFFC, rnw=1, `mem_rdata`=8'h34 → `mem_oe`=1 and `mem_addr`=FFFC for 2 cycles; `cpu_ready` pulses in cycle 3; `cpu_rdata`=8'h34.
- **DMA write:** `dma_addr`=16'h0200, `dma_wdata`=8'hA5, rnw=0 → `mem_we`=1 for 2 cycles with `mem_wdata`=A5; `dma_done` pulses once; `dma_rdata` unchanged.
- **Contention:** both requests held high for 4 transfers → grants alternate CPU, DMA, CPU, DMA; strobes spaced 4 cycles apart.
- **Withdrawal:** `cpu_req` dropped in the first ACCESS cycle → transfer still completes and `cpu_ready` still pulses; then IDLE with `busy`=0.
- **Reset mid-operation:** `nrst` pulsed low during ACCESS → state returns to IDLE immediately; `mem_oe`=0; no strobe; `cpu_rdata` = 0.
